// File: rtl/nmi_sram_slave_if.sv
// NMI request/response bus between one initiator and one memory slave.
//
// Handshake: the initiator raises valid together with addr/wdata/wstrb.
// It holds them until the slave answers. The slave answers with a single-cycle
// ready pulse, and rdata is meaningful only in that cycle. A transfer completes
// on the rising edge where ready=1. wstrb==4'b0000 encodes a read.
interface nmi_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  wstrb,
        output ready,
        output rdata
    );

    modport master (
        output valid,
        output addr,
        output wdata,
        output wstrb,
        input  ready,
        input  rdata
    );
endinterface

// File: rtl/nmi_sram_slave.sv
// Word-organised SRAM slave on the NMI bus with a configurable number of
// wait states, byte-strobe writes and a sticky out-of-range error flag.
module nmi_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    nmi_if.slave       nmi,
    output logic       err_o,
    output logic [1:0] dbg_state
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0] BASE_W    = BASE_ADDR[31:2];
    localparam logic [29:0] LAST_W    = BASE_W + 30'(DEPTH_WORDS - 1);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      wait_cnt;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic            hit_q;
    logic            ready_q;
    logic [31:0]     mem [DEPTH_WORDS];

    // Address decode of the live request; byte-lane bits play no part.
    logic [29:0] req_word;
    logic        req_hit;
    logic        unused_addr_lsb;
    assign req_word        = nmi.addr[31:2];
    assign req_hit         = (req_word >= BASE_W) && (req_word <= LAST_W);
    assign unused_addr_lsb = ^nmi.addr[1:0];

    // Read data is only driven during the response cycle, and only for hit reads.
    logic [31:0] read_word;
    assign read_word = (hit_q && (wstrb_q == 4'b0000)) ? mem[idx_q] : 32'h0000_0000;

    assign nmi.ready = ready_q;
    assign nmi.rdata = ready_q ? read_word : 32'h0000_0000;
    assign dbg_state = state;

    // Access sequencer: latch the request, count wait states, pulse ready once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            idx_q    <= '0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'h0;
            hit_q    <= 1'b0;
            ready_q  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (nmi.valid) begin
                        idx_q   <= nmi.addr[AW+1:2];
                        wdata_q <= nmi.wdata;
                        wstrb_q <= nmi.wstrb;
                        hit_q   <= req_hit;
                        if (WAIT_CYCLES == 0) begin
                            state   <= RESP;
                            ready_q <= 1'b1;
                            if (!req_hit) err_o <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state   <= RESP;
                        ready_q <= 1'b1;
                        if (!hit_q) err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage write on the response edge; only strobed bytes of a hit change.
    always_ff @(posedge clk_i) begin
        if (state == RESP && hit_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_nmi_sram_slave.sv
// Bench for nmi_sram_slave: one instance with one wait state and one with none,
// driven by directed and random accesses against a word-array reference model.
module tb_nmi_sram_slave;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    nmi_if bus0 ();
    nmi_if bus1 ();

    logic        v   [2];
    logic [31:0] a   [2];
    logic [31:0] wd  [2];
    logic [3:0]  ws  [2];
    logic        err0, err1;
    logic [1:0]  st0, st1;

    assign bus0.valid = v[0];
    assign bus0.addr  = a[0];
    assign bus0.wdata = wd[0];
    assign bus0.wstrb = ws[0];
    assign bus1.valid = v[1];
    assign bus1.addr  = a[1];
    assign bus1.wdata = wd[1];
    assign bus1.wstrb = ws[1];

    nmi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .nmi(bus0), .err_o(err0), .dbg_state(st0)
    );
    nmi_sram_slave #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .nmi(bus1), .err_o(err1), .dbg_state(st1)
    );

    // ---------------- reference model ----------------
    logic [31:0] mm     [2][DEPTH];
    bit          merr   [2];
    int          free_c [2];
    int          wc     [2];

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    int          cyc_q0 [$];
    int          cyc_q1 [$];
    bit          chk_q0 [$];
    bit          chk_q1 [$];
    bit          err_q0 [$];
    bit          err_q1 [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] @cyc %0d: got %h, expected %h", name, i, cyc, got, exp);
        end
    endtask

    function automatic logic rdy(input int i);
        return (i == 0) ? bus0.ready : bus1.ready;
    endfunction

    task automatic push(input int i, input logic [31:0] d, input int c, input bit chk, input bit e);
        if (i == 0) begin
            exp_q0.push_back(d); cyc_q0.push_back(c); chk_q0.push_back(chk); err_q0.push_back(e);
        end else begin
            exp_q1.push_back(d); cyc_q1.push_back(c); chk_q1.push_back(chk); err_q1.push_back(e);
        end
    endtask

    task automatic mon(input int i, input logic r, input logic [31:0] rd, input logic e);
        logic [31:0] ed;
        int          ec;
        bit          ek;
        bit          ee;
        bit          have;
        if (r) begin
            have = (i == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
            n_tests++;
            if (!have) begin
                n_fail++;
                $display("FAIL unexpected_ready[dut%0d] @cyc %0d: got ready=1, expected no response", i, cyc);
            end else begin
                if (i == 0) begin
                    ed = exp_q0.pop_front(); ec = cyc_q0.pop_front(); ek = chk_q0.pop_front(); ee = err_q0.pop_front();
                end else begin
                    ed = exp_q1.pop_front(); ec = cyc_q1.pop_front(); ek = chk_q1.pop_front(); ee = err_q1.pop_front();
                end
                check("ready_cycle", i, cyc, ec);
                if (ek) check("rdata", i, rd, ed);
                check("err_o", i, {31'b0, e}, {31'b0, ee});
            end
        end else begin
            check("rdata_idle", i, rd, 32'h0);
        end
    endtask

    // Monitor: every response is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            mon(0, bus0.ready, bus0.rdata, err0);
            mon(1, bus1.ready, bus1.rdata, err1);
        end
    end

    // ---------------- driver ----------------
    // Called on a falling edge; returns on the falling edge where ready is seen.
    task automatic access(input int i, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input bit drop_early, input bit hold_after);
        int          start;
        int          ec;
        int          idx;
        bit          hit;
        bit          to;
        logic [31:0] ed;
        v[i] = 1'b1; a[i] = addr; wd[i] = wdata; ws[i] = wstrb;
        start = (cyc > free_c[i]) ? cyc : free_c[i];
        ec = start + wc[i] + 1;
        free_c[i] = ec + 1;
        hit = (addr >= BASE) && (addr <= BASE + 32'(DEPTH * 4 - 1));
        idx = int'((addr - BASE) >> 2);
        ed = 32'h0;
        if (!hit) begin
            merr[i] = 1'b1;
        end else if (wstrb == 4'b0000) begin
            ed = mm[i][idx];
        end else begin
            for (int b = 0; b < 4; b++) if (wstrb[b]) mm[i][idx][8*b +: 8] = wdata[8*b +: 8];
        end
        push(i, ed, ec, (wstrb == 4'b0000), merr[i]);
        to = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (drop_early) begin
                v[i] = 1'b0; a[i] = $urandom; wd[i] = $urandom; ws[i] = 4'($urandom);
            end
            if (rdy(i)) begin
                to = 1'b0;
                break;
            end
        end
        n_tests++;
        if (to) begin
            n_fail++;
            $display("FAIL ready_timeout[dut%0d] @cyc %0d: got no ready, expected ready by cyc %0d", i, cyc, ec);
        end
        if (!hold_after) v[i] = 1'b0;
    endtask

    task automatic rand_access(input int i);
        logic [31:0] addr;
        logic [3:0]  strb;
        if ($urandom_range(0, 99) < 88) addr = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
        else if ($urandom_range(0, 1) == 0) addr = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
        else addr = BASE - 32'($urandom_range(1, 4096));
        strb = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        access(i, addr, $urandom, strb, 1'b0, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        wc[0] = 0; wc[1] = 1;
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; a[i] = 32'h0; wd[i] = 32'h0; ws[i] = 4'h0;
            merr[i] = 1'b0; free_c[i] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_ready", 1, {31'b0, bus1.ready}, 32'h0);
        check("reset_rdata", 1, bus1.rdata, 32'h0);
        check("reset_err", 1, {31'b0, err1}, 32'h0);
        check("reset_state", 1, {30'b0, st1}, 32'h0);
        check("reset_ready", 0, {31'b0, bus0.ready}, 32'h0);
        check("reset_state", 0, {30'b0, st0}, 32'h0);
        rst = 1'b0;
        free_c[0] = cyc; free_c[1] = cyc;

        // Preload every word of both memories
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < DEPTH; w++)
                access(i, BASE + 32'(w * 4), $urandom, 4'hF, 1'b0, 1'b0);

        // Basic write then read, one wait state
        access(1, 32'h3000_0010, 32'hA5A5_1234, 4'hF, 1'b0, 1'b0);
        access(1, 32'h3000_0010, 32'h0, 4'h0, 1'b0, 1'b0);

        // Byte strobes
        access(1, 32'h3000_0030, 32'h1122_3344, 4'hF, 1'b0, 1'b0);
        access(1, 32'h3000_0030, 32'hFFFF_FFFF, 4'b0101, 1'b0, 1'b0);
        access(1, 32'h3000_0030, 32'h0, 4'h0, 1'b0, 1'b0);

        // Boundary: last word hits, word 0 untouched, low address bits ignored
        access(1, 32'h3000_03FC, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
        access(1, 32'h3000_03FC, 32'h0, 4'h0, 1'b0, 1'b0);
        access(1, 32'h3000_0000, 32'h0, 4'h0, 1'b0, 1'b0);
        access(1, 32'h3000_0013, 32'h0, 4'h0, 1'b0, 1'b0);

        // Miss just past the end and just below the base; error stays set
        access(1, 32'h3000_0400, 32'h0, 4'h0, 1'b0, 1'b0);
        access(1, 32'h3000_0400, 32'h7777_7777, 4'hF, 1'b0, 1'b0);
        access(1, 32'h2FFF_FFFC, 32'h0, 4'h0, 1'b0, 1'b0);
        access(1, 32'h3000_0000, 32'h0, 4'h0, 1'b0, 1'b0);
        access(1, 32'h3000_03FC, 32'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("err_sticky", 1, {31'b0, err1}, {31'b0, merr[1]});

        // Zero wait states, valid held high across four reads
        access(0, 32'h3000_0000, 32'h0, 4'h0, 1'b0, 1'b1);
        access(0, 32'h3000_0004, 32'h0, 4'h0, 1'b0, 1'b1);
        access(0, 32'h3000_03F8, 32'h0, 4'h0, 1'b0, 1'b1);
        access(0, 32'h3000_03FC, 32'h0, 4'h0, 1'b0, 1'b0);

        // Valid dropped right after acceptance: the write still lands
        @(negedge clk);
        access(1, 32'h3000_0040, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
        access(1, 32'h3000_0040, 32'h0, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        access(0, 32'h3000_0044, 32'h0BAD_C0DE, 4'b1100, 1'b1, 1'b0);
        access(0, 32'h3000_0044, 32'h0, 4'h0, 1'b0, 1'b0);

        // Randomised traffic on both instances
        for (int n = 0; n < 150; n++) begin
            rand_access(1);
            rand_access(0);
        end

        // Reset during the wait state of a write
        @(negedge clk);
        v[1] = 1'b1; a[1] = 32'h3000_0020; wd[1] = 32'h5555_AAAA; ws[1] = 4'hF;
        @(negedge clk);
        check("midop_state_before", 1, {30'b0, st1}, 32'h1);
        rst = 1'b1;
        #1;
        check("midop_state_async", 1, {30'b0, st1}, 32'h0);
        check("midop_ready_async", 1, {31'b0, bus1.ready}, 32'h0);
        check("midop_err_async", 1, {31'b0, err1}, 32'h0);
        v[1] = 1'b0;
        merr[0] = 1'b0; merr[1] = 1'b0;
        repeat (2) @(negedge clk);
        check("midop_ready_held", 1, {31'b0, bus1.ready}, 32'h0);
        rst = 1'b0;
        free_c[0] = cyc; free_c[1] = cyc;
        repeat (3) @(negedge clk);
        check("post_rst_state", 1, {30'b0, st1}, 32'h0);
        access(1, 32'h3000_0020, 32'h0, 4'h0, 1'b0, 1'b0);
        access(0, 32'h3000_03FC, 32'h0, 4'h0, 1'b0, 1'b0);

        // Drain and confirm nothing is outstanding
        repeat (5) @(negedge clk);
        check("queue_empty", 0, 32'(exp_q0.size()), 32'h0);
        check("queue_empty", 1, 32'(exp_q1.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nmi_sram_slave.md
NMI_SRAM_SLAVE -- requirements
Module: nmi_sram_slave

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning byte address of word 0, aligned to DEPTH_WORDS*4.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit storage words, a power of 2 in the range 16..4096.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 1, meaning extra wait states per access, in the range 0..15.
REQ-004 The block SHALL have port clk_i, input, width 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_i, input, width 1; reset is asynchronous and active-high.
REQ-006 The block SHALL have port nmi.valid, input, width 1, request valid from the initiator, held until ready.
REQ-007 The block SHALL have port nmi.addr, input, width 32, byte address.
REQ-008 The block SHALL have port nmi.wdata, input, width 32, write data.
REQ-009 The block SHALL have port nmi.wstrb, input, width 4, byte write enables; 4'b0000 means read.
REQ-010 The block SHALL have port nmi.ready, output, width 1, one-cycle completion pulse.
REQ-011 The block SHALL have port nmi.rdata, output, width 32, read data, valid while ready=1.
REQ-012 The block SHALL have port err_o, output, width 1, sticky flag for an out-of-range access.
REQ-013 The nmi.* ports SHALL be carried on the nmi_if interface in its slave modport.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 In IDLE with valid=1, the block SHALL latch addr, wdata, wstrb and the hit flag, then go to WAIT, or to RESP when WAIT_CYCLES=0.
REQ-016 Hit SHALL be defined as addr[31:2] lying in [BASE_ADDR[31:2], BASE_ADDR[31:2]+DEPTH_WORDS-1].
REQ-017 The word index SHALL be addr[$clog2(DEPTH_WORDS)+1:2]; addr[1:0] SHALL be ignored.
REQ-018 WAIT SHALL load a down-counter with WAIT_CYCLES-1 on entry, decrement it each cycle, and exit to RESP when it reaches 0.
REQ-019 RESP SHALL drive ready=1 for exactly one cycle, then return to IDLE.
REQ-020 Latency SHALL be WAIT_CYCLES+1 cycles from the first cycle with valid=1 sampled in IDLE to the cycle with ready=1.
REQ-021 On a hit write, the block SHALL update only the bytes whose wstrb bit is 1, at the RESP clock edge.
REQ-022 On a hit read, rdata SHALL equal the stored word during RESP.
REQ-023 On a miss, rdata SHALL be 32'h0000_0000, no storage SHALL change, ready SHALL still pulse after normal latency, and err_o SHALL be set to 1.
REQ-024 rdata SHALL be 32'h0 in every cycle where ready=0.
REQ-025 In the cycle after RESP, the FSM SHALL be in IDLE and SHALL accept a new request if valid=1, giving back-to-back throughput of one access per WAIT_CYCLES+2 cycles.
REQ-026 Once a request is accepted, the block SHALL ignore changes on valid, addr, wdata and wstrb until it returns to IDLE; a dropped valid SHALL NOT abort the access (the write still occurs).
REQ-027 A read or write to the last word (index DEPTH_WORDS-1) SHALL behave as a hit, and BASE_ADDR+DEPTH_WORDS*4 SHALL be a miss, with no wrap-around.

Reset
REQ-028 When rst_i=1, the block SHALL force IDLE, ready=0, rdata=0, err_o=0 and wait counter=0 immediately, independent of clk_i.
REQ-029 Reset asserted mid-access SHALL abort that access with no ready pulse and no write.
REQ-030 Storage contents SHALL NOT be cleared by reset.
REQ-031 After rst_i deasserts, the first accepted request SHALL occur no earlier than the first rising edge with rst_i=0.

Verification
REQ-032 The bench SHALL check this scenario with WAIT_CYCLES=1: write addr=32'h3000_0010, wdata=32'hA5A5_1234, wstrb=4'hF, then read the same address -> ready 2 cycles after valid for each access, rdata=32'hA5A5_1234.
REQ-033 The bench SHALL check byte strobes: preload 32'h1122_3344, write wdata=32'hFFFF_FFFF with wstrb=4'b0101 -> readback 32'h11FF_33FF.
REQ-034 The bench SHALL check a miss: read 32'h3000_0400 (DEPTH 256) -> ready after normal latency, rdata=0, err_o=1 and remaining 1 until reset.
REQ-035 The bench SHALL check the boundary: word 255 at 32'h3000_03FC is written and read correctly, and word 0 is unchanged.
REQ-036 The bench SHALL check reset mid-op: assert rst_i during WAIT of a write to 32'h3000_0020 -> ready never pulses, the old contents remain, and the FSM is in IDLE.
REQ-037 The bench SHALL check WAIT_CYCLES=0 back-to-back: valid held high across 4 reads -> ready pulses every 2 cycles, each with correct rdata.
